fibonacci_index_decoder: RTL and testbench
==========================================

Name: fibonacci_index_decoder

Overview:
- Inverse of the team's Fibonacci sequence generator: accepts a value and returns the index n of the largest Fibonacci term F(n) that is less than or equal to it, plus an exact-match flag.
- Indexing: F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2).
- Used by checkers and consumers of the generator's output stream to recover term position.
- Iterative, one term per cycle, valid/ready handshake on input and output.

Parameters:
- WIDTH, 32, width of input value and Fibonacci terms.
- IDX_W, 7, width of the index output. Must hold the maximum index for WIDTH, which is 47 for WIDTH=32.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  in_value is valid
- in_ready  output  1  high only in IDLE
- in_value  input  WIDTH  value to decode
- out_valid  output  1  result valid; held until accepted
- out_ready  input  1  consumer accepts result
- out_index  output  IDX_W  index n of the largest F(n) <= in_value
- out_is_fib  output  1  1 if in_value == F(out_index)
- out_fib  output  WIDTH  F(out_index)

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_index=0, out_is_fib=0, out_fib=0.
- Internal registers:
  - a: WIDTH bits.
  - b: WIDTH+1 bits, so the sum cannot wrap.
  - n: IDX_W bits.
  - v: WIDTH bits, captured value.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: v<=in_value, a<=0, b<=1, n<=0, go to SEARCH.
  - in_value is ignored after capture.
- SEARCH (in_ready=0, out_valid=0), evaluated once per cycle in this priority order:
  - If a==v: out_is_fib<=1, out_index<=n, out_fib<=a, go to DONE.
  - Else if b>v (unsigned, WIDTH+1-bit compare): out_is_fib<=0, out_index<=n, out_fib<=a, go to DONE.
  - Else: a<=b[WIDTH-1:0], b<=a+b, n<=n+1.
- Width rule: the advance branch only runs when b<=v<2^WIDTH, so a+b<2^(WIDTH+1). There is no overflow and no wrap. Termination is guaranteed because b eventually exceeds v.
- Value 1: resolves as index 1, not 2. The first match wins.
- DONE:
  - out_valid=1; outputs are stable until handshake.
  - On out_ready: out_valid<=0, go to IDLE.
  - out_index, out_is_fib and out_fib hold their last value while out_valid is 0.
- Latency:
  - Accept edge, then k SEARCH cycles, then out_valid rises. k = final n + 1.
  - Value 0: k=1.
  - Value 2^32-1, WIDTH=32: k=48, index 47.
- Throughput:
  - No overlap. in_ready is low from the accept edge until the cycle after the output handshake.
  - Minimum spacing between accepts is k+2 cycles.
- Simultaneous events:
  - in_valid is ignored outside IDLE.
  - out_ready is ignored outside DONE.
  - out_ready held high gives a 1-cycle DONE.
- Reset mid-operation: immediate return to IDLE with reset values. The in-flight value is discarded and no out_valid is produced.

Optional Feature:
- Macro: FIB_REMAINDER_EN.
- Defined:
  - Adds output port out_remainder, WIDTH bits.
  - out_remainder is registered on the DONE transition as v - a (distance to the largest Fibonacci term <= v).
  - Reset value is 0.
  - Equals 0 whenever out_is_fib=1.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset asserted mid-SEARCH for value 1000 -> in_ready=1 and out_valid=0 asynchronously. The next request, value 21, returns index 8, is_fib=1, fib=21.
- Value 0 -> index 0, is_fib=1, fib=0, out_valid 2 edges after accept. Value 1 -> index 1, is_fib=1, fib=1.
- Value 4 -> index 4, is_fib=0, fib=3, remainder=1 (with FIB_REMAINDER_EN). Value 100 -> index 11, is_fib=0, fib=89, remainder=11.
- Value 32'hFFFF_FFFF -> index 47, is_fib=0, fib=2971215073, 48 SEARCH cycles. Value 2971215073 -> index 47, is_fib=1.
- Backpressure: out_ready held 0 for 10 cycles -> outputs stable and in_ready=0 throughout; in_valid pulses are ignored. Raising out_ready -> out_valid falls next edge, in_ready returns to 1.
- Generator cross-check: decode each of F(0)..F(47) (e.g. from the generator) -> out_index==n and is_fib=1 for every term. Each term+1 for n>=4 -> is_fib=0, index==n.

Source files
------------

// File: rtl/fibonacci_index_decoder.sv
// Purpose : inverse Fibonacci lookup; returns the index n of the largest F(n) <= in_value, plus exact-match flag.
// Latency : accept edge, then final_n+1 SEARCH cycles, then out_valid rises (value 0 -> 1 SEARCH cycle).
// Backpr. : one request in flight; in_ready only in IDLE, result held in DONE until out_ready.
//
// Ports:
//   clock, reset          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready     request handshake, in_value captured on accept
//   out_valid/out_ready   result handshake, outputs stable while out_valid=1
//   out_index             index n of the largest F(n) <= in_value
//   out_is_fib            1 when in_value == F(out_index)
//   out_fib               F(out_index)
//   out_remainder         in_value - F(out_index); present only when FIB_REMAINDER_EN is defined
module fibonacci_index_decoder #(
   parameter int WIDTH = 32,
   parameter int IDX_W = 7
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_value,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic             out_is_fib,
   output logic [WIDTH-1:0] out_fib
`ifdef FIB_REMAINDER_EN
   ,
   output logic [WIDTH-1:0] out_remainder
`endif
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a;   // F(n)
   logic [WIDTH:0]   b;   // F(n+1); one extra bit so F(n+1) past the top term still fits
   logic [IDX_W-1:0] n;
   logic [WIDTH-1:0] v;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         in_ready   <= 1'b1;
         out_valid  <= 1'b0;
         out_index  <= '0;
         out_is_fib <= 1'b0;
         out_fib    <= '0;
         a          <= '0;
         b          <= '0;
         n          <= '0;
         v          <= '0;
`ifdef FIB_REMAINDER_EN
         out_remainder <= '0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  v        <= in_value;
                  a        <= '0;
                  b        <= {{WIDTH{1'b0}}, 1'b1};
                  n        <= '0;
                  in_ready <= 1'b0;
                  state    <= SEARCH;
               end
            end
            SEARCH: begin
               // Exact match is tested first so that value 1 resolves to F(1), not F(2).
               if (a == v) begin
                  out_is_fib <= 1'b1;
                  out_index  <= n;
                  out_fib    <= a;
                  out_valid  <= 1'b1;
                  state      <= DONE;
`ifdef FIB_REMAINDER_EN
                  out_remainder <= '0;
`endif
               end else if (b > {1'b0, v}) begin
                  out_is_fib <= 1'b0;
                  out_index  <= n;
                  out_fib    <= a;
                  out_valid  <= 1'b1;
                  state      <= DONE;
`ifdef FIB_REMAINDER_EN
                  out_remainder <= v - a;
`endif
               end else begin
                  // Only reached with b <= v < 2^WIDTH, so b fits in WIDTH bits and a+b cannot wrap.
                  a <= b[WIDTH-1:0];
                  b <= {1'b0, a} + b;
                  n <= n + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fibonacci_index_decoder.sv
module tb_fibonacci_index_decoder;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_value;
   logic        out_valid;
   logic        out_ready;
   logic [6:0]  out_index;
   logic        out_is_fib;
   logic [31:0] out_fib;
`ifdef FIB_REMAINDER_EN
   logic [31:0] out_remainder;
`endif

   fibonacci_index_decoder #(.WIDTH(32), .IDX_W(7)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_value   (in_value),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_index  (out_index),
      .out_is_fib (out_is_fib),
      .out_fib    (out_fib)
`ifdef FIB_REMAINDER_EN
      ,
      .out_remainder (out_remainder)
`endif
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [6:0]  idx;
      logic        is_fib;
      logic [31:0] fib;
      logic [31:0] rem;
   } exp_t;

   exp_t            sb[$];
   longint unsigned fibt[0:47];
   int              checks   = 0;
   int              failures = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Reference: scan the table upward, skipping the duplicate 1 so the lowest index wins.
   task automatic push_exp(input logic [31:0] val);
      exp_t e;
      int   idx;
      idx = 0;
      for (int i = 0; i < 48; i++) begin
         if (fibt[i] <= longint'(val) && (i == 0 || fibt[i] != fibt[i-1])) idx = i;
      end
      e.idx    = 7'(idx);
      e.fib    = fibt[idx][31:0];
      e.is_fib = (fibt[idx] == longint'(val));
      e.rem    = val - fibt[idx][31:0];
      sb.push_back(e);
   endtask

   task automatic wait_out(output int edges);
      edges = 1;
      while (!out_valid && edges < 200) begin
         @(posedge clock); #1;
         edges++;
      end
      if (!out_valid) chk("out_valid_timeout", out_valid, 1);
   endtask

   task automatic compare_out(input string tag, input exp_t e, input int edges);
      chk({tag, "_index"},  out_index,  e.idx);
      chk({tag, "_is_fib"}, out_is_fib, e.is_fib);
      chk({tag, "_fib"},    out_fib,    e.fib);
      chk({tag, "_latency"}, edges,     e.idx + 2);
`ifdef FIB_REMAINDER_EN
      chk({tag, "_rem"},    out_remainder, e.rem);
`endif
   endtask

   // One request with out_ready already high: result handshakes on the edge after out_valid rises.
   task automatic request(input string tag, input logic [31:0] val);
      exp_t e;
      int   edges;
      @(negedge clock);
      in_valid = 1'b1;
      in_value = val;
      push_exp(val);
      @(posedge clock); #1;
      in_valid = 1'b0;
      in_value = $urandom;
      chk({tag, "_in_ready_low"}, in_ready, 0);
      wait_out(edges);
      e = sb.pop_front();
      compare_out(tag, e, edges);
      @(posedge clock); #1;
      chk({tag, "_valid_drop"}, out_valid, 0);
      chk({tag, "_in_ready_back"}, in_ready, 1);
      chk({tag, "_index_held"}, out_index, e.idx);
   endtask

   initial begin
      exp_t e;
      int   edges;
      fibt[0] = 0;
      fibt[1] = 1;
      for (int i = 2; i < 48; i++) fibt[i] = fibt[i-1] + fibt[i-2];

      reset = 1'b1; in_valid = 1'b0; in_value = '0; out_ready = 1'b1;
      #1;
      chk("rst_in_ready",  in_ready,  1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_index",     out_index, 0);
      chk("rst_is_fib",    out_is_fib, 0);
      chk("rst_fib",       out_fib,   0);
`ifdef FIB_REMAINDER_EN
      chk("rst_rem",       out_remainder, 0);
`endif
      repeat (2) @(posedge clock);
      @(negedge clock); reset = 1'b0;

      // Reset in the middle of a search: asynchronous return to IDLE, no result.
      @(negedge clock); in_valid = 1'b1; in_value = 32'd1000;
      @(posedge clock); #1; in_valid = 1'b0;
      repeat (5) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      chk("midrst_in_ready",  in_ready,  1);
      chk("midrst_out_valid", out_valid, 0);
      @(negedge clock); reset = 1'b0;
      repeat (20) begin
         @(posedge clock); #1;
         chk("midrst_no_result", out_valid, 0);
      end
      request("v21", 32'd21);

      request("v0",    32'd0);
      request("v1",    32'd1);
      request("v4",    32'd4);
      request("v100",  32'd100);
      request("vmax",  32'hFFFF_FFFF);
      request("vf47",  32'd2971215073);

      // Backpressure: result must hold and extra requests must be ignored.
      out_ready = 1'b0;
      @(negedge clock); in_valid = 1'b1; in_value = 32'd100; push_exp(32'd100);
      @(posedge clock); #1; in_valid = 1'b0;
      wait_out(edges);
      e = sb.pop_front();
      compare_out("bp", e, edges);
      for (int c = 0; c < 10; c++) begin
         @(negedge clock); in_valid = c[0]; in_value = 32'd7;
         @(posedge clock); #1;
         chk("bp_in_ready",  in_ready,  0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_index",     out_index, e.idx);
         chk("bp_fib",       out_fib,   e.fib);
         chk("bp_is_fib",    out_is_fib, e.is_fib);
      end
      @(negedge clock); in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clock); #1;
      chk("bp_valid_drop", out_valid, 0);
      chk("bp_in_ready_back", in_ready, 1);
      chk("bp_hold_fib", out_fib, e.fib);

      // Every generator term, then term+1 which must miss but keep the same index.
      for (int k = 0; k < 48; k++) request("term", fibt[k][31:0]);
      for (int k = 4; k < 48; k++) request("term_p1", fibt[k][31:0] + 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
